// File: rtl/trap_ctrl.sv
// ============================================================================
// trap_ctrl : machine-mode interrupt entry / mret return sequencer
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_ctrl #(
  parameter int DW           = 32,
  parameter int DRAIN_CYCLES = 2,
  parameter int CAUSE_MTI    = 7,
  parameter int CAUSE_MEI    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          timer_pend,
  input  logic          ext_pend,
  input  logic          mstatus_mie,
  input  logic          is_mret,
  input  logic          pipe_stall,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] mtvec,
  input  logic [DW-1:0] mepc,
  output logic          stall_req,
  output logic          trap_we,
  output logic          mret_we,
  output logic [DW-1:0] mepc_wdata,
  output logic [DW-1:0] mcause_wdata,
  output logic          pc_redirect,
  output logic [DW-1:0] pc_target,
  output logic          flush,
  output logic          busy
);

  localparam int CW = 4;

  localparam logic [DW-1:0] INT_FLAG   = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MCAUSE_MTI = INT_FLAG | DW'(CAUSE_MTI);
  localparam logic [DW-1:0] MCAUSE_MEI = INT_FLAG | DW'(CAUSE_MEI);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2,
    ST_MRET  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] epc_q, epc_d;
  logic [DW-1:0] mcause_q, mcause_d;

  logic          irq;
  logic [DW-1:0] vec_base;
  logic [DW-1:0] vec_target;

  assign irq = mstatus_mie & (timer_pend | ext_pend);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      epc_q    <= '0;
      mcause_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      epc_q    <= epc_d;
      mcause_q <= mcause_d;
    end
  end

  // Once DRAIN is entered the trap is committed; pend/MIE are no longer looked at.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    epc_d    = epc_q;
    mcause_d = mcause_q;
    unique case (state_q)
      ST_IDLE: begin
        if (irq && !pipe_stall) begin
          state_d  = ST_DRAIN;
          cnt_d    = DRAIN_LOAD;
          epc_d    = pc_in;
          mcause_d = ext_pend ? MCAUSE_MEI : MCAUSE_MTI;
        end else if (is_mret && !pipe_stall) begin
          state_d = ST_MRET;
        end
      end
      ST_DRAIN: begin
        if (!pipe_stall) begin
          if (cnt_q == CW'(1)) begin
            state_d = ST_TRAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      ST_TRAP: state_d = ST_IDLE;
      ST_MRET: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Vectored mode offsets by 4*cause; the interrupt flag is shifted out here.
  assign vec_base   = {mtvec[DW-1:2], 2'b00};
  assign vec_target = mtvec[0] ? (vec_base + {mcause_q[DW-3:0], 2'b00}) : vec_base;

  always_comb begin
    stall_req   = 1'b0;
    trap_we     = 1'b0;
    mret_we     = 1'b0;
    pc_redirect = 1'b0;
    flush       = 1'b0;
    busy        = 1'b0;
    pc_target   = '0;
    unique case (state_q)
      ST_DRAIN: begin
        stall_req = 1'b1;
        busy      = 1'b1;
      end
      ST_TRAP: begin
        stall_req   = 1'b1;
        busy        = 1'b1;
        trap_we     = 1'b1;
        pc_redirect = 1'b1;
        flush       = 1'b1;
        pc_target   = vec_target;
      end
      ST_MRET: begin
        stall_req   = 1'b1;
        busy        = 1'b1;
        mret_we     = 1'b1;
        pc_redirect = 1'b1;
        flush       = 1'b1;
        pc_target   = mepc;
      end
      default: ;
    endcase
  end

  assign mepc_wdata   = epc_q;
  assign mcause_wdata = mcause_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
`default_nettype none

module tb_trap_ctrl;

  localparam int DW = 32;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          timer_pend, ext_pend, mstatus_mie, is_mret, pipe_stall;
  logic [DW-1:0] pc_in, mtvec, mepc;
  logic          stall_req, trap_we, mret_we, pc_redirect, flush, busy;
  logic [DW-1:0] mepc_wdata, mcause_wdata, pc_target;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Model state: non-stalled cycles left before commit, plus one-cycle action flags.
  int            m_left = 0;
  bit            m_trap = 1'b0;
  bit            m_mret = 1'b0;
  logic [DW-1:0] m_epc  = '0;
  int            m_code = 0;

  trap_ctrl #(.DW(DW), .DRAIN_CYCLES(D), .CAUSE_MTI(7), .CAUSE_MEI(11)) dut (
    .clk(clk), .rst_n(rst_n), .timer_pend(timer_pend), .ext_pend(ext_pend),
    .mstatus_mie(mstatus_mie), .is_mret(is_mret), .pipe_stall(pipe_stall),
    .pc_in(pc_in), .mtvec(mtvec), .mepc(mepc), .stall_req(stall_req),
    .trap_we(trap_we), .mret_we(mret_we), .mepc_wdata(mepc_wdata),
    .mcause_wdata(mcause_wdata), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left <= 0; m_trap <= 1'b0; m_mret <= 1'b0; m_epc <= '0; m_code <= 0;
    end else if (m_trap || m_mret) begin
      m_trap <= 1'b0; m_mret <= 1'b0;
    end else if (m_left > 0) begin
      if (!pipe_stall) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_trap <= 1'b1;
      end
    end else if (mstatus_mie && (timer_pend || ext_pend) && !pipe_stall) begin
      m_left <= D;
      m_epc  <= pc_in;
      m_code <= ext_pend ? 11 : 7;
    end else if (is_mret && !pipe_stall) begin
      m_mret <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic          act;
      logic [DW-1:0] base, tgt, mc;
      act  = m_trap || m_mret;
      base = mtvec & ~32'd3;
      tgt  = m_trap ? (mtvec[0] ? base + 32'(m_code * 4) : base) : (m_mret ? mepc : '0);
      mc   = (m_code == 0) ? '0 : (32'h8000_0000 | 32'(m_code));
      chk("busy",        32'(busy),        32'(m_left > 0 || act));
      chk("stall_req",   32'(stall_req),   32'(m_left > 0 || act));
      chk("trap_we",     32'(trap_we),     32'(m_trap));
      chk("mret_we",     32'(mret_we),     32'(m_mret));
      chk("pc_redirect", 32'(pc_redirect), 32'(act));
      chk("flush",       32'(flush),       32'(act));
      chk("pc_target",   pc_target,        tgt);
      chk("mepc_wdata",  mepc_wdata,       m_epc);
      chk("mcause",      mcause_wdata,     mc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    rst_n = 1'b1; timer_pend = 0; ext_pend = 0; mstatus_mie = 0; is_mret = 0; pipe_stall = 0;
    repeat (n) step();
  endtask

  // Runs from an accepting cycle until trap_we, stalling cycles 1..st_len.
  task automatic run_to_trap(input int st_len, output int k, output int mret_seen);
    k = 0;
    mret_seen = 0;
    do begin
      step();
      k++;
      timer_pend = 0; ext_pend = 0; mstatus_mie = 0; is_mret = 0;
      pipe_stall = (k <= st_len);
      if (mret_we) mret_seen++;
    end while (!trap_we && k < 30);
  endtask

  initial begin
    int k, ms, seen;
    rst_n = 0; timer_pend = 0; ext_pend = 0; mstatus_mie = 0; is_mret = 0; pipe_stall = 0;
    pc_in = '0; mtvec = '0; mepc = '0;
    step();
    chk_on = 1'b1;
    step();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset mcause", mcause_wdata, 32'd0);
    quiet(2);

    // 1: timer interrupt, direct mode
    timer_pend = 1; mstatus_mie = 1; pc_in = 32'h100; mtvec = 32'h200;
    run_to_trap(0, k, ms);
    chk("t1 latency", 32'(k), 32'(D + 1));
    chk("t1 mepc", mepc_wdata, 32'h100);
    chk("t1 mcause", mcause_wdata, 32'h8000_0007);
    chk("t1 target", pc_target, 32'h200);
    chk("t1 flush", 32'(flush), 32'd1);
    quiet(2);

    // 2: both pending, vectored mode, external wins
    timer_pend = 1; ext_pend = 1; mstatus_mie = 1; pc_in = 32'h104; mtvec = 32'h201;
    run_to_trap(0, k, ms);
    chk("t2 mcause", mcause_wdata, 32'h8000_000B);
    chk("t2 target", pc_target, 32'h22C);
    quiet(2);

    // 3: pending masked by MIE, then mret
    timer_pend = 1; mstatus_mie = 0;
    step();
    chk("t3 busy", 32'(busy), 32'd0);
    chk("t3 stall", 32'(stall_req), 32'd0);
    is_mret = 1; mepc = 32'h344;
    step();
    is_mret = 0;
    chk("t3 mret_we", 32'(mret_we), 32'd1);
    chk("t3 target", pc_target, 32'h344);
    quiet(2);

    // 4: interrupt and mret together
    timer_pend = 1; mstatus_mie = 1; is_mret = 1; pc_in = 32'h480; mtvec = 32'h200;
    run_to_trap(0, k, ms);
    chk("t4 trap", 32'(trap_we), 32'd1);
    chk("t4 mepc", mepc_wdata, 32'h480);
    chk("t4 no mret", 32'(ms), 32'd0);
    step();
    chk("t4 no mret after", 32'(mret_we), 32'd0);
    quiet(2);

    // 5: four stall cycles in DRAIN with pend dropped
    timer_pend = 1; mstatus_mie = 1; pc_in = 32'h500;
    run_to_trap(4, k, ms);
    chk("t5 latency", 32'(k), 32'(D + 1 + 4));
    chk("t5 mepc", mepc_wdata, 32'h500);
    quiet(2);

    // 6: reset in DRAIN
    timer_pend = 1; mstatus_mie = 1; pc_in = 32'h600;
    step();
    timer_pend = 0; mstatus_mie = 0;
    chk("t6 draining", 32'(busy), 32'd1);
    rst_n = 0;
    step();
    chk("t6 busy", 32'(busy), 32'd0);
    chk("t6 outs", {26'd0, stall_req, trap_we, mret_we, pc_redirect, flush, busy}, 32'd0);
    chk("t6 mepc", mepc_wdata, 32'd0);
    chk("t6 target", pc_target, 32'd0);
    rst_n = 1;
    seen = 0;
    repeat (6) begin
      step();
      if (trap_we) seen++;
    end
    chk("t6 no trap", 32'(seen), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      timer_pend  = ($urandom_range(0, 3) == 0);
      ext_pend    = ($urandom_range(0, 4) == 0);
      mstatus_mie = ($urandom_range(0, 1) == 0);
      is_mret     = ($urandom_range(0, 5) == 0);
      pipe_stall  = ($urandom_range(0, 3) == 0);
      pc_in       = $urandom;
      mtvec       = $urandom;
      mepc        = $urandom;
      step();
    end

    quiet(2);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
